fetch_ctrl: RTL and testbench

Instruction-fetch controller that drives the program counter and the IF/ID pipeline latch. It sits directly downstream of the PC register: it consumes PC_current and returns PC_write/PC_new to that register. It also runs a req/ack handshake with a variable-latency instruction memory and fills the IF/ID latch. Stalls from ID and branch/jump redirects from later stages are handled here, including the case where a memory response is still in flight.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, runs the req/ack
// handshake with a variable-latency instruction memory and fills IF/ID.
// Stalls from ID and redirects from later stages are resolved here,
// including redirects that arrive while a memory response is still pending.
module fetch_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC_current,
    output logic              PC_write,
    output logic [ADDR_W-1:0] PC_new,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [DATA_W-1:0] IF_ID_instr,
    output logic [ADDR_W-1:0] IF_ID_pc_plus1,
    output logic              IF_ID_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hold_instr;
    logic [ADDR_W-1:0] hold_pc_plus1;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = PC_current + ADDR_W'(1);

    // PC update: redirect wins, otherwise advance whenever IF/ID accepts an instruction
    always_comb begin
        PC_write = 1'b0;
        PC_new   = pc_inc;
        if (redirect) begin
            PC_write = 1'b1;
            PC_new   = redirect_target;
        end else if (state == REQ && imem_ack && !stall) begin
            PC_write = 1'b1;
            PC_new   = pc_inc;
        end else if (state == HOLD && !stall) begin
            PC_write = 1'b1;
            PC_new   = hold_pc_plus1;
        end
    end

    // Fetch FSM with registered memory request and IF/ID latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            imem_req       <= 1'b0;
            imem_addr      <= '0;
            IF_ID_instr    <= '0;
            IF_ID_pc_plus1 <= '0;
            IF_ID_valid    <= 1'b0;
            hold_instr     <= '0;
            hold_pc_plus1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        imem_addr   <= redirect_target;
                        IF_ID_valid <= 1'b0;
                    end else begin
                        imem_addr <= PC_current;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        IF_ID_valid <= 1'b0;
                        if (imem_ack) begin
                            // response is stale: reissue at the target right away
                            imem_addr <= redirect_target;
                            imem_req  <= 1'b1;
                        end else begin
                            // old request must still complete before reissuing
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            hold_instr    <= imem_data;
                            hold_pc_plus1 <= pc_inc;
                            imem_req      <= 1'b0;
                            state         <= HOLD;
                        end else begin
                            IF_ID_instr    <= imem_data;
                            IF_ID_pc_plus1 <= pc_inc;
                            IF_ID_valid    <= 1'b1;
                            imem_addr      <= pc_inc;
                        end
                    end else if (!stall) begin
                        IF_ID_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        IF_ID_valid <= 1'b0;
                        imem_addr   <= redirect_target;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end else if (!stall) begin
                        IF_ID_instr    <= hold_instr;
                        IF_ID_pc_plus1 <= hold_pc_plus1;
                        IF_ID_valid    <= 1'b1;
                        imem_addr      <= hold_pc_plus1;
                        imem_req       <= 1'b1;
                        state          <= REQ;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        IF_ID_valid <= 1'b0;
                        if (imem_ack) begin
                            imem_addr <= redirect_target;
                            state     <= REQ;
                        end
                    end else if (imem_ack) begin
                        // PC already holds the redirect destination
                        imem_addr <= PC_current;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// stall/redirect/latency traffic, checked against a program-order model.
module tb_fetch_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] PC_current;
    logic              PC_write;
    logic [ADDR_W-1:0] PC_new;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic [DATA_W-1:0] IF_ID_instr;
    logic [ADDR_W-1:0] IF_ID_pc_plus1;
    logic              IF_ID_valid;

    fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .PC_current      (PC_current),
        .PC_write        (PC_write),
        .PC_new          (PC_new),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .IF_ID_instr     (IF_ID_instr),
        .IF_ID_pc_plus1  (IF_ID_pc_plus1),
        .IF_ID_valid     (IF_ID_valid)
    );

    always #5 clock = ~clock;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_deliv  = 0;
    int                mem_cnt  = 0;
    int                mem_wait = 0;
    bit                rand_wait = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              last_pcw;
    logic [ADDR_W-1:0] last_pcn;

    // Memory image: odd multiplier keeps every address's word distinct
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply reset mid-cycle, check outputs clear immediately, release after an edge
    task automatic do_reset(input logic [ADDR_W-1:0] start_pc);
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("rst_req",    32'(imem_req), 32'(0));
        chk("rst_valid",  32'(IF_ID_valid), 32'(0));
        chk("rst_addr",   32'(imem_addr), 32'(0));
        chk("rst_instr",  32'(IF_ID_instr), 32'(0));
        chk("rst_pcp1",   32'(IF_ID_pc_plus1), 32'(0));
        @(posedge clock);
        #1;
        reset      = 1'b0;
        pc         = start_pc;
        PC_current = pc;
        mem_cnt    = 0;
    endtask

    // One clock cycle: drive inputs, model memory/PC register, check fetch rules
    task automatic step(input logic s, input logic r, input logic [ADDR_W-1:0] t, input logic spur);
        logic              pcw, v0, q0, k0, deliv;
        logic [ADDR_W-1:0] pcn, p0, a0, pc0, nxt0;
        logic [DATA_W-1:0] i0;
        stall           = s;
        redirect        = r;
        redirect_target = t;
        imem_ack        = (imem_req && (mem_cnt >= mem_wait)) || spur;
        imem_data       = mem_word(imem_addr);
        #2;
        pcw  = PC_write;
        pcn  = PC_new;
        v0   = IF_ID_valid;
        i0   = IF_ID_instr;
        p0   = IF_ID_pc_plus1;
        q0   = imem_req;
        a0   = imem_addr;
        k0   = imem_ack;
        pc0  = PC_current;
        nxt0 = pc0 + ADDR_W'(1);
        @(posedge clock);
        #1;
        if (pcw) pc = pcn;
        PC_current = pc;
        if (q0) begin
            mem_cnt = k0 ? 0 : mem_cnt + 1;
            if (k0 && rand_wait) mem_wait = $urandom_range(0, 3);
        end
        deliv    = !s && !r && IF_ID_valid;
        last_pcw = pcw;
        last_pcn = pcn;
        if (deliv) n_deliv++;
        chk("pc_write", 32'(pcw), 32'(r || deliv));
        if (r) begin
            chk("redir_pc_new", 32'(pcn), 32'(t));
            chk("redir_flush", 32'(IF_ID_valid), 32'(0));
        end else if (s) begin
            chk("stall_valid", 32'(IF_ID_valid), 32'(v0));
            chk("stall_instr", IF_ID_instr, i0);
            chk("stall_pcp1", 32'(IF_ID_pc_plus1), 32'(p0));
        end
        if (deliv) begin
            chk("deliv_pc_new", 32'(pcn), 32'(nxt0));
            chk("deliv_pcp1", 32'(IF_ID_pc_plus1), 32'(nxt0));
            chk("deliv_instr", IF_ID_instr, mem_word(pc0));
        end
        if (q0 && !k0) begin
            chk("req_held", 32'(imem_req), 32'(1));
            chk("addr_stable", 32'(imem_addr), 32'(a0));
        end
    endtask

    initial begin
        int d0;
        int pulses;
        stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        imem_ack = 1'b0; imem_data = '0; PC_current = '0; pc = '0; reset = 1'b0;

        // Zero-wait streaming from PC 0
        do_reset(10'd0);
        mem_wait = 0;
        step(0, 0, 0, 0);
        chk("s1_req", 32'(imem_req), 32'(1));
        chk("s1_addr", 32'(imem_addr), 32'(0));
        chk("s1_valid", 32'(IF_ID_valid), 32'(0));
        for (int k = 2; k <= 6; k++) begin
            step(0, 0, 0, 0);
            chk("s1_stream_pcp1", 32'(IF_ID_pc_plus1), 32'(k - 1));
            chk("s1_stream_addr", 32'(imem_addr), 32'(k - 1));
            chk("s1_stream_valid", 32'(IF_ID_valid), 32'(1));
        end

        // Two wait states at PC 5
        do_reset(10'd5);
        mem_wait = 2;
        pulses   = 0;
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0);
            if (last_pcw) pulses++;
            chk("s2_req", 32'(imem_req), 32'(1));
            chk("s2_addr", 32'(imem_addr), 32'(5));
            chk("s2_bubble", 32'(IF_ID_valid), 32'(0));
        end
        step(0, 0, 0, 0);
        if (last_pcw) pulses++;
        chk("s2_pulses", 32'(pulses), 32'(1));
        chk("s2_pc_new", 32'(last_pcn), 32'(6));
        chk("s2_pcp1", 32'(IF_ID_pc_plus1), 32'(6));

        // Stall for three cycles on the ack of PC 8
        do_reset(10'd7);
        mem_wait = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            chk("s3_frozen_pcp1", 32'(IF_ID_pc_plus1), 32'(8));
            chk("s3_frozen_valid", 32'(IF_ID_valid), 32'(1));
            chk("s3_req_low", 32'(imem_req), 32'(0));
            chk("s3_pc_hold", 32'(pc), 32'(8));
        end
        step(0, 0, 0, 0);
        chk("s3_rel_pcp1", 32'(IF_ID_pc_plus1), 32'(9));
        chk("s3_rel_pcw", 32'(last_pcw), 32'(1));
        chk("s3_rel_pcn", 32'(last_pcn), 32'(9));

        // Redirect while PC 20 is pending
        do_reset(10'd20);
        mem_wait = 2;
        step(0, 0, 0, 0);
        step(0, 1, 10'h100, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s4_drop_valid", 32'(IF_ID_valid), 32'(0));
        chk("s4_new_addr", 32'(imem_addr), 32'(10'h100));
        chk("s4_new_req", 32'(imem_req), 32'(1));
        mem_wait = 0;
        step(0, 0, 0, 0);
        chk("s4_pcp1", 32'(IF_ID_pc_plus1), 32'(10'h101));
        chk("s4_valid", 32'(IF_ID_valid), 32'(1));

        // Redirect during HOLD with stall asserted
        do_reset(10'd30);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 10'h40, 0);
        chk("s5_valid", 32'(IF_ID_valid), 32'(0));
        chk("s5_addr", 32'(imem_addr), 32'(10'h40));
        chk("s5_req", 32'(imem_req), 32'(1));
        step(0, 0, 0, 0);
        chk("s5_pcp1", 32'(IF_ID_pc_plus1), 32'(10'h41));

        // Wrap at 1023, then reset in the middle of a pending request
        do_reset(10'd1022);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s6_wrap_pcp1", 32'(IF_ID_pc_plus1), 32'(0));
        chk("s6_wrap_pcn", 32'(last_pcn), 32'(0));
        chk("s6_wrap_addr", 32'(imem_addr), 32'(0));
        mem_wait = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        do_reset(10'h200);
        step(0, 0, 0, 1);
        chk("s6_spur_valid", 32'(IF_ID_valid), 32'(0));
        chk("s6_spur_addr", 32'(imem_addr), 32'(10'h200));
        chk("s6_spur_req", 32'(imem_req), 32'(1));

        // Random stalls, redirects and memory latency
        rand_wait = 1'b1;
        mem_wait  = $urandom_range(0, 3);
        d0        = n_deliv;
        for (int k = 0; k < 2000; k++) begin
            step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0),
                 ADDR_W'($urandom), 0);
        end
        chk("rand_liveness", 32'((n_deliv - d0) > 150), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
